// File: rtl/fpga_eth_pkg.sv
// -----------------------------------------------------------------------------
// fpga_eth_pkg
// Shared constants for the Ethernet/IPv4/UDP frame path (receive and transmit).
// Frames are carried as 32-bit beats. Two pad bytes in front of the Ethernet
// header align the IPv4 header to a beat boundary. Beat n holds frame bytes
// 4n..4n+3, with byte 4n in bits [31:24].
// Contents: header field beat indices, protocol constants, broadcast MAC,
//           receive FSM state type.
// -----------------------------------------------------------------------------
package fpga_eth_pkg;

  // Beat index of each header field checked on receive
  localparam logic [4:0] BEAT_MAC_HI = 5'd0;   // dst MAC [47:32] in [15:0]
  localparam logic [4:0] BEAT_MAC_LO = 5'd1;   // dst MAC [31:0]
  localparam logic [4:0] BEAT_ETYPE  = 5'd3;   // ethertype in [15:0]
  localparam logic [4:0] BEAT_PROTO  = 5'd6;   // IPv4 protocol in [23:16]
  localparam logic [4:0] BEAT_UDP    = 5'd9;   // UDP destination port in [15:0]

  // Upper bound of the 5-bit beat counter
  localparam logic [4:0] BEAT_CNT_MAX = 5'd31;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPPROTO_UDP    = 8'h11;
  localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,   // waiting for a sof beat
    HDR,    // header beats, fields checked on the fly
    PAY,    // control beat and ADC data beats
    DROP    // frame rejected, waiting for eof or a new sof
  } rx_state_e;

endpackage

// File: rtl/adc_hdr_check.sv
// -----------------------------------------------------------------------------
// adc_hdr_check
// Per-beat header field comparison for the ADC frame receiver. It keeps a
// sticky "all fields so far matched" flag for the current frame.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-low reset
//   start         sof beat: beat 0 of a new frame; restarts the check
//   beat          a non-sof header beat is being presented
//   idx           beat index of the beat on data
//   data          beat data
//   hwaddr        own MAC address
//   udpport       accepted UDP destination port
//   match         sticky match, including the beat currently presented
// -----------------------------------------------------------------------------
module adc_hdr_check
  import fpga_eth_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        beat,
  input  logic [4:0]  idx,
  input  logic [31:0] data,
  input  logic [47:0] hwaddr,
  input  logic [15:0] udpport,
  output logic        match
);

  logic [15:0] mac_hi_q;
  logic        ok_q;
  logic        beat_ok;
  logic [47:0] dst_mac;

  // The destination MAC straddles beats 0 and 1, so the upper half is held
  // from the sof beat and the whole address is judged on beat 1.
  assign dst_mac = {mac_hi_q, data};

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves beat_ok unassigned and no latch is inferred.
  always_comb begin
    beat_ok = 1'b1;
    case (idx)
      BEAT_MAC_LO: beat_ok = (dst_mac == hwaddr) || (dst_mac == BCAST_MAC);
      BEAT_ETYPE:  beat_ok = (data[15:0] == ETHERTYPE_IPV4);
      BEAT_PROTO:  beat_ok = (data[23:16] == IPPROTO_UDP);
      BEAT_UDP:    beat_ok = (data[15:0] == udpport);
      default:     beat_ok = 1'b1;
    endcase
  end

  // A sof beat carries nothing that can fail on its own.
  assign match = start ? 1'b1 : (ok_q && beat_ok);

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ok_q <= 1'b0;
    end else if (start) begin
      ok_q <= 1'b1;
    end else if (beat) begin
      ok_q <= ok_q && beat_ok;
    end
  end

  // NOTE: pure datapath holding register: it is always written on the sof
  // beat before it is read, so it carries no reset.
  always_ff @(posedge clock) begin
    if (start) begin
      mac_hi_q <= data[15:0];
    end
  end

endmodule

// File: rtl/adc_frame_rx.sv
// -----------------------------------------------------------------------------
// adc_frame_rx
// Receives beat-serial Ethernet/IPv4/UDP frames that carry one ADC sample set.
// It accepts only frames addressed to this node (own or broadcast MAC), IPv4,
// UDP to the configured port, and exactly HDR_BEATS+PAY_BEATS beats long. Then
// it presents the reassembled 256-bit ADC word, its exponent and the frame
// sequence number.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   validin           beat qualifier; cycles without it are stalls
//   sof, eof          first/last beat markers (meaningful with validin)
//   datain            beat data
//   inthwaddr         own MAC address
//   intudpport        accepted UDP destination port
//   rxdataout         ADC data, beat HDR_BEATS+1 in the top word
//   rxexpout          ADC exponent
//   rxseqout          sequence number of the last accepted frame
//   rxvalidout        1-cycle strobe: new rxdataout/rxexpout/rxseqout
//   rxdrop            1-cycle strobe: a frame was rejected
//   rxseqgap          with rxvalidout: sequence did not follow the last one
// -----------------------------------------------------------------------------
module adc_frame_rx
  import fpga_eth_pkg::*;
#(
  parameter int unsigned HDR_BEATS = 11,
  parameter int unsigned PAY_BEATS = 9
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        validin,
  input  logic                        sof,
  input  logic                        eof,
  input  logic [31:0]                 datain,
  input  logic [47:0]                 inthwaddr,
  input  logic [15:0]                 intudpport,
  output logic [32*(PAY_BEATS-1)-1:0] rxdataout,
  output logic [3:0]                  rxexpout,
  output logic [15:0]                 rxseqout,
  output logic                        rxvalidout,
  output logic                        rxdrop,
  output logic                        rxseqgap
);

  localparam int unsigned DATA_W    = 32 * (PAY_BEATS - 1);
  localparam logic [4:0]  LAST_HDR  = 5'(HDR_BEATS - 1);
  localparam logic [4:0]  CTRL_BEAT = 5'(HDR_BEATS);
  localparam logic [4:0]  LAST_BEAT = 5'(HDR_BEATS + PAY_BEATS - 1);

  rx_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;       // index of the next beat of the frame
  logic        flag_q, flag_d;     // rxdrop already raised for this frame
  logic        seq_seen_q;

  logic        drop_d;
  logic        accept;
  logic        chk_start;
  logic        chk_beat;
  logic        hdr_match;
  logic        cap_ctl;
  logic        shift_en;
  logic [4:0]  chk_idx;

  // The last data word is taken straight from datain when the frame is
  // accepted, so the assembly register holds one word less than the output.
  logic [DATA_W-33:0] asm_q;
  logic [15:0]        seq_q;
  logic [3:0]         exp_q;

  assign chk_idx = chk_start ? BEAT_MAC_HI : cnt_q;

  adc_hdr_check u_hdr_check (
    .clock   (clock),
    .reset   (reset),
    .start   (chk_start),
    .beat    (chk_beat),
    .idx     (chk_idx),
    .data    (datain),
    .hwaddr  (inthwaddr),
    .udpport (intudpport),
    .match   (hdr_match)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flag_d    = flag_q;
    drop_d    = 1'b0;
    accept    = 1'b0;
    chk_start = 1'b0;
    chk_beat  = 1'b0;
    cap_ctl   = 1'b0;
    shift_en  = 1'b0;

    if (validin) begin
      if (sof) begin
        // A sof beat always starts a new frame; whatever was in flight is
        // abandoned and reported unless it was reported already.
        chk_start = 1'b1;
        if ((state_q != IDLE) && !((state_q == DROP) && flag_q)) begin
          drop_d = 1'b1;
        end
        if (eof) begin
          drop_d  = 1'b1;           // a one-beat frame can never be valid
          state_d = IDLE;
        end else begin
          state_d = HDR;
          cnt_d   = 5'd1;
          flag_d  = 1'b0;
        end
      end else begin
        unique case (state_q)
          IDLE: ;                   // beats outside a frame are ignored
          HDR: begin
            chk_beat = 1'b1;
            cnt_d    = cnt_q + 5'd1;
            if (eof) begin
              drop_d  = 1'b1;
              state_d = IDLE;
            end else if (!hdr_match) begin
              // Reported when the frame ends, not now.
              state_d = DROP;
              flag_d  = 1'b0;
            end else if (cnt_q == LAST_HDR) begin
              state_d = PAY;
            end
          end
          PAY: begin
            if (cnt_q == LAST_BEAT) begin
              if (eof) begin
                accept  = 1'b1;
                state_d = IDLE;
              end else begin
                // Overlong frame: report now, then discard up to its eof.
                drop_d  = 1'b1;
                flag_d  = 1'b1;
                state_d = DROP;
                cnt_d   = cnt_q + 5'd1;
              end
            end else if (eof) begin
              drop_d  = 1'b1;
              state_d = IDLE;
            end else begin
              cnt_d    = cnt_q + 5'd1;
              cap_ctl  = (cnt_q == CTRL_BEAT);
              shift_en = (cnt_q != CTRL_BEAT);
            end
          end
          DROP: begin
            if (eof) begin
              drop_d  = !flag_q;
              state_d = IDLE;
            end else if (cnt_q != BEAT_CNT_MAX) begin
              cnt_d = cnt_q + 5'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      flag_q     <= 1'b0;
      seq_seen_q <= 1'b0;
      rxdataout  <= '0;
      rxexpout   <= '0;
      rxseqout   <= '0;
      rxvalidout <= 1'b0;
      rxdrop     <= 1'b0;
      rxseqgap   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flag_q     <= flag_d;
      rxvalidout <= accept;
      rxdrop     <= drop_d;
      // rxseqout still holds the previous accepted sequence number here.
      rxseqgap   <= accept && seq_seen_q && (seq_q != rxseqout + 16'd1);
      if (accept) begin
        rxdataout  <= {asm_q, datain};
        rxexpout   <= exp_q;
        rxseqout   <= seq_q;
        seq_seen_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (cap_ctl) begin
      seq_q <= datain[31:16];
      exp_q <= datain[3:0];
    end
    if (shift_en) begin
      asm_q <= {asm_q[DATA_W-65:0], datain};
    end
  end

endmodule

// File: tb/tb_adc_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_adc_frame_rx
// Scoreboard bench for adc_frame_rx. Frames are described by their field
// values and serialised into beats from the byte layout of an
// Ethernet/IPv4/UDP frame. A frame-level model turns each description into
// the expected strobes and pushes them into a queue. An independent monitor
// pops an entry for every strobe the DUT raises. It also checks that the
// outputs hold between accepted frames.
// -----------------------------------------------------------------------------
module tb_adc_frame_rx;

  localparam logic [47:0] OWN_MAC  = 48'h02_1A_2B_3C_4D_5E;
  localparam logic [47:0] BC_MAC   = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] OWN_PORT = 16'd5001;

  logic         clock = 1'b0;
  logic         reset;
  logic         validin, sof, eof;
  logic [31:0]  datain;
  logic [47:0]  inthwaddr;
  logic [15:0]  intudpport;
  logic [255:0] rxdataout;
  logic [3:0]   rxexpout;
  logic [15:0]  rxseqout;
  logic         rxvalidout, rxdrop, rxseqgap;

  adc_frame_rx dut (
    .clock      (clock),
    .reset      (reset),
    .validin    (validin),
    .sof        (sof),
    .eof        (eof),
    .datain     (datain),
    .inthwaddr  (inthwaddr),
    .intudpport (intudpport),
    .rxdataout  (rxdataout),
    .rxexpout   (rxexpout),
    .rxseqout   (rxseqout),
    .rxvalidout (rxvalidout),
    .rxdrop     (rxdrop),
    .rxseqgap   (rxseqgap)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [47:0]  mac;
    logic [15:0]  etype;
    logic [7:0]   proto;
    logic [15:0]  port;
    logic [15:0]  seq;
    logic [3:0]   exp;
    logic [255:0] data;
    int           len;       // beats sent, sof on beat 0
    bit           has_eof;   // eof on the last beat sent
  } frame_t;

  typedef struct {
    bit           is_acc;
    logic [255:0] data;
    logic [3:0]   exp;
    logic [15:0]  seq;
    bit           gap;
    int           trig;      // global beat index that causes the strobe
  } exp_t;

  exp_t sb[$];
  int   beat_cyc[$];          // cycle in which each beat was presented
  int   n_cmp = 0;
  int   n_bad = 0;

  // model state
  bit          pending_abort = 0;  // frame in flight to be reported by next sof
  bit          m_seen = 0;
  logic [15:0] m_last = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic drive_cycle(input logic v, input logic s, input logic e, input logic [31:0] d);
    @(posedge clock);
    #1;
    validin = v;
    sof     = s;
    eof     = e;
    datain  = d;
  endtask

  // Stall cycles carry random sof/eof/data that must be ignored.
  task automatic drive_beat(input logic s, input logic e, input logic [31:0] d, input int stalls);
    repeat (stalls) drive_cycle(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom);
    drive_cycle(1'b1, s, e, d);
    beat_cyc.push_back(cyc);
  endtask

  task automatic push_drop(input int trig);
    exp_t e;
    e.is_acc = 1'b0; e.data = '0; e.exp = '0; e.seq = '0; e.gap = 1'b0; e.trig = trig;
    sb.push_back(e);
  endtask

  task automatic push_acc(input frame_t f, input int trig);
    exp_t e;
    e.is_acc = 1'b1; e.data = f.data; e.exp = f.exp; e.seq = f.seq; e.trig = trig;
    e.gap = m_seen && (int'(f.seq) != (int'(m_last) + 1) % 65536);
    m_seen = 1'b1;
    m_last = f.seq;
    sb.push_back(e);
  endtask

  function automatic bit fields_ok(input frame_t f);
    return ((f.mac == OWN_MAC) || (f.mac == BC_MAC)) && (f.etype == 16'h0800) &&
           (f.proto == 8'h11) && (f.port == OWN_PORT);
  endfunction

  function automatic frame_t good_frame(input logic [15:0] seq, input logic [3:0] exp,
                                        input logic [255:0] data);
    frame_t f;
    f.mac = OWN_MAC; f.etype = 16'h0800; f.proto = 8'h11; f.port = OWN_PORT;
    f.seq = seq; f.exp = exp; f.data = data; f.len = 20; f.has_eof = 1'b1;
    return f;
  endfunction

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  task automatic send_frame(input frame_t f, input int gmin, input int gmax);
    logic [7:0]  b [80];
    logic [31:0] w;
    int          start;
    bit          ok;
    start = beat_cyc.size();
    if (pending_abort) begin
      push_drop(start);
      pending_abort = 1'b0;
    end
    ok = fields_ok(f);
    if (ok && f.len >= 20 && !(f.has_eof && f.len == 20)) push_drop(start + 19);
    else if (ok && f.has_eof && f.len == 20)             push_acc(f, start + 19);
    else if (f.has_eof)                                   push_drop(start + f.len - 1);
    else                                                  pending_abort = 1'b1;

    // 2 pad + 14 Ethernet + 20 IPv4 + 8 UDP = 44 header bytes, then payload
    for (int i = 0; i < 80; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) b[2 + i] = f.mac[47 - 8*i -: 8];
    b[14] = f.etype[15:8]; b[15] = f.etype[7:0];
    b[25] = f.proto;                                    // IPv4 byte 9
    b[38] = f.port[15:8];  b[39] = f.port[7:0];         // UDP bytes 2..3
    b[44] = f.seq[15:8];   b[45] = f.seq[7:0];
    b[46] = 8'h00;         b[47] = {4'h0, f.exp};
    for (int k = 0; k < 32; k++) b[48 + k] = f.data[255 - 8*k -: 8];

    for (int n = 0; n < f.len; n++) begin
      if (n < 20) w = {b[4*n], b[4*n+1], b[4*n+2], b[4*n+3]};
      else        w = $urandom;
      drive_beat(n == 0, f.has_eof && (n == f.len - 1), w,
                 (n == 0) ? 0 : int'($urandom_range(gmax, gmin)));
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: pops one expectation per strobe and tracks held outputs.
  initial begin : monitor
    exp_t         e;
    logic [255:0] h_data;
    logic [3:0]   h_exp;
    logic [15:0]  h_seq;
    h_data = '0; h_exp = '0; h_seq = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        h_data = '0; h_exp = '0; h_seq = '0;
        check("reset_rxvalidout", rxvalidout, 0);
        check("reset_rxdrop", rxdrop, 0);
      end else if (rxvalidout || rxdrop) begin
        if (sb.size() == 0) begin
          check("spurious_rxvalidout", rxvalidout, 0);
          check("spurious_rxdrop", rxdrop, 0);
        end else begin
          e = sb.pop_front();
          check("strobe_is_accept", rxvalidout, e.is_acc);
          check("strobe_is_drop", rxdrop, !e.is_acc);
          check("strobe_cycle", cyc, beat_cyc[e.trig] + 1);
          if (e.is_acc) begin
            check("rxseqgap", rxseqgap, e.gap);
            h_data = e.data; h_exp = e.exp; h_seq = e.seq;
          end
        end
      end
      if (!rxvalidout) check("rxseqgap_without_valid", rxseqgap, 0);
      check("rxdataout", rxdataout, h_data);
      check("rxexpout", rxexpout, h_exp);
      check("rxseqout", rxseqout, h_seq);
    end
  end

  initial begin : stimulus
    frame_t       f;
    logic [255:0] d18;
    logic [15:0]  nseq;
    logic [47:0]  wmac;
    bit           prev_eof;
    int           r;

    reset = 1'b0;
    validin = 1'b0; sof = 1'b0; eof = 1'b0; datain = '0;
    inthwaddr = OWN_MAC; intudpport = OWN_PORT;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;

    // basic accepted frame, back-to-back beats
    d18 = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    send_frame(good_frame(16'd5, 4'hA, d18), 0, 0);
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("basic_rxdataout", rxdataout, d18);
    check("basic_rxseqout", rxseqout, 16'd5);
    check("basic_rxexpout", rxexpout, 4'hA);

    // same frame with 3 stall cycles between beats
    send_frame(good_frame(16'd5, 4'hA, d18), 3, 3);

    // UDP port off by one
    f = good_frame(16'd6, 4'h3, rand_data());
    f.port = OWN_PORT + 16'd1;
    send_frame(f, 0, 1);

    // eof on beat 15, then a frame cut by sof at its beat 7, then a good one
    f = good_frame(16'd6, 4'h1, rand_data()); f.len = 16;
    send_frame(f, 0, 0);
    f = good_frame(16'd6, 4'h2, rand_data()); f.len = 7; f.has_eof = 1'b0;
    send_frame(f, 0, 0);
    send_frame(good_frame(16'd6, 4'h4, rand_data()), 0, 1);

    // reset while beat 14 of a frame is in flight
    f = good_frame(16'd7, 4'h5, rand_data()); f.len = 15; f.has_eof = 1'b0;
    send_frame(f, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("async_reset_rxdataout", rxdataout, 0);
    check("async_reset_rxexpout", rxexpout, 0);
    check("async_reset_rxseqout", rxseqout, 0);
    check("async_reset_rxvalidout", rxvalidout, 0);
    check("async_reset_rxdrop", rxdrop, 0);
    check("async_reset_rxseqgap", rxseqgap, 0);
    pending_abort = 1'b0;
    m_seen = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    send_frame(good_frame(16'hFFFE, 4'h6, rand_data()), 0, 2);

    // sequence wrap and gap
    send_frame(good_frame(16'hFFFF, 4'h7, rand_data()), 0, 1);
    send_frame(good_frame(16'h0000, 4'h8, rand_data()), 0, 1);
    send_frame(good_frame(16'h0002, 4'h9, rand_data()), 0, 1);

    // randomized mix of good, broken, short, long and cut frames
    nseq = 16'h0003;
    prev_eof = 1'b1;
    for (int i = 0; i < 60; i++) begin
      nseq = ($urandom_range(9, 0) == 0) ? 16'($urandom) : nseq + 16'd1;
      f = good_frame(nseq, 4'($urandom), rand_data());
      r = $urandom_range(99, 0);
      if (r < 10) f.mac = BC_MAC;
      else if (r < 18) begin
        wmac = {16'($urandom), $urandom};
        if (wmac == OWN_MAC || wmac == BC_MAC) wmac = wmac ^ 48'h1;
        f.mac = wmac;
      end
      else if (r < 24) f.etype = 16'h86DD;
      else if (r < 30) f.proto = 8'h06;
      else if (r < 36) f.port = OWN_PORT ^ 16'($urandom_range(65535, 1));
      else if (r < 46) f.len = $urandom_range(25, 1);
      else if (r < 54) begin
        f.len = $urandom_range(24, 1);
        f.has_eof = 1'b0;
      end
      if (pending_abort && f.len < 2) f.len = 2;
      if (i == 59) f = good_frame(nseq, 4'hF, rand_data());
      if (prev_eof && $urandom_range(3, 0) == 0) begin
        repeat ($urandom_range(3, 1)) drive_cycle(1'b1, 1'b0, 1'($urandom_range(1, 0)), $urandom);
      end
      send_frame(f, 0, $urandom_range(2, 0));
      prev_eof = f.has_eof;
    end

    repeat (10) drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
